// File: rtl/id_ex_hazard.sv
// ID/EX pipeline register with load-use stall detection, branch flush and
// memory-hold freeze. Flushes arriving during a hold are remembered and applied on release.
module id_ex_hazard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        id_alusrc,
    input  logic        id_uses_rt,
    input  logic [3:0]  id_aluop,
    input  logic        ex_flush,
    input  logic        mem_hold,
    output logic        ex_valid,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic        ex_regdst,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_alusrc,
    output logic [3:0]  ex_aluop,
    output logic        pc_write,
    output logic        ifid_write,
    output logic [15:0] stall_cnt,
    output logic        flush_pending,
    output logic [0:0]  dbg_state_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        regdst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic [3:0]  aluop;
    } idex_t;

    logic [0:0]  state_q, state_d;
    logic        flush_pending_q, flush_pending_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    idex_t       ex_q, ex_d, id_pkt;
    logic        lu, fl;

    // An invalid ID slot still carries its operands but never any side-effecting control.
    always_comb begin
        id_pkt          = '0;
        id_pkt.valid    = id_valid;
        id_pkt.rs       = id_rs;
        id_pkt.rt       = id_rt;
        id_pkt.rd       = id_rd;
        id_pkt.rs_data  = id_rs_data;
        id_pkt.rt_data  = id_rt_data;
        id_pkt.imm      = id_imm;
        id_pkt.regdst   = id_regdst   & id_valid;
        id_pkt.regwrite = id_regwrite & id_valid;
        id_pkt.memread  = id_memread  & id_valid;
        id_pkt.memwrite = id_memwrite & id_valid;
        id_pkt.memtoreg = id_memtoreg & id_valid;
        id_pkt.alusrc   = id_alusrc   & id_valid;
        id_pkt.aluop    = id_valid ? id_aluop : 4'd0;
    end

    assign lu = ex_q.valid & ex_q.memread & (ex_q.rt != 5'd0) & id_valid &
                ((ex_q.rt == id_rs) | (id_uses_rt & (ex_q.rt == id_rt)));
    assign fl = ex_flush | flush_pending_q;

    // pc_write/ifid_write are enables, not a handshake: high means the front end
    // may advance this cycle; they are purely combinational from state and inputs.
    always_comb begin
        state_d         = mem_hold ? ST_HOLD : ST_RUN;
        flush_pending_d = flush_pending_q;
        stall_cnt_d     = stall_cnt_q;
        ex_d            = ex_q;
        pc_write        = 1'b0;
        ifid_write      = 1'b0;
        if (mem_hold) begin
            flush_pending_d = flush_pending_q | ex_flush;
        end else begin
            flush_pending_d = 1'b0;
            if (fl) begin
                ex_d       = '0;
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end else if (lu) begin
                ex_d = '0;
                if (stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end else begin
                ex_d       = id_pkt;
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            flush_pending_q <= 1'b0;
            stall_cnt_q     <= 16'd0;
            ex_q            <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            stall_cnt_q     <= stall_cnt_d;
            ex_q            <= ex_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_rs_data    = ex_q.rs_data;
    assign ex_rt_data    = ex_q.rt_data;
    assign ex_imm        = ex_q.imm;
    assign ex_regdst     = ex_q.regdst;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_memtoreg   = ex_q.memtoreg;
    assign ex_alusrc     = ex_q.alusrc;
    assign ex_aluop      = ex_q.aluop;
    assign stall_cnt     = stall_cnt_q;
    assign flush_pending = flush_pending_q;
    assign dbg_state_o   = state_q;

endmodule
